lc3b_regfile_sb: RTL and testbench



---
 rtl/lc3b_regfile_sb_pkg.sv | 17 +
 rtl/lc3b_regfile_sb_counter.sv | 55 +++++
 rtl/lc3b_regfile_sb.sv | 140 ++++++++++++++
 tb/tb_lc3b_regfile_sb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_regfile_sb_pkg.sv
// Shared LC-3b types for the register file and its scoreboard.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  localparam int LC3B_CNT_W    = 2;
  localparam int LC3B_NUM_REGS = 8;

  typedef logic [LC3B_CNT_W-1:0] lc3b_sbcnt;

  // One-hot decode of a register index across the eight registers.
  function automatic logic [LC3B_NUM_REGS-1:0] reg_onehot(input lc3b_reg r);
    return {{(LC3B_NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/lc3b_regfile_sb_counter.sv
// Per-register outstanding-write counter for the scoreboard.
// Counts issued-but-not-written-back writes; never wraps in either direction.
module lc3b_sb_counter
  import lc3b_types::*;
#(
  parameter int CNT_W = LC3B_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_next;

  // Next count: a simultaneous inc and dec cancel; the ends of the range hold.
  always_comb begin
    cnt_next = cnt;
    if (inc && !dec) begin
      if (cnt != CNT_MAX) begin
        cnt_next = cnt + CNT_W'(1);
      end else begin
        cnt_next = cnt;
      end
    end else if (dec && !inc) begin
      if (cnt != CNT_ZERO) begin
        cnt_next = cnt - CNT_W'(1);
      end else begin
        cnt_next = cnt;
      end
    end else begin
      cnt_next = cnt;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= CNT_ZERO;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign nonzero   = (cnt != CNT_ZERO);
  // A writeback with nothing outstanding is a scoreboard protocol error.
  assign underflow = dec && !inc && (cnt == CNT_ZERO);

endmodule

// File: rtl/lc3b_regfile_sb.sv
// LC-3b eight-entry register file with write-first bypass and a
// per-register scoreboard that stalls decode on RAW hazards and on
// counter saturation.
module lc3b_regfile_sb
  import lc3b_types::*;
#(
  parameter int WIDTH = $bits(lc3b_word),
  parameter int CNT_W = LC3B_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  lc3b_reg                  src_a,
  input  lc3b_reg                  src_b,
  output logic [WIDTH-1:0]         reada,
  output logic [WIDTH-1:0]         readb,
  input  logic                     wb_ld,
  input  lc3b_reg                  wb_dest,
  input  logic [WIDTH-1:0]         wb_data,
  input  logic                     issue_valid,
  input  logic                     issue_use_a,
  input  logic                     issue_use_b,
  input  logic                     issue_ld,
  input  lc3b_reg                  issue_dest,
  output logic                     stall,
  output logic [LC3B_NUM_REGS-1:0] busy,
  output logic                     sb_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0]         regs      [LC3B_NUM_REGS];
  logic [CNT_W-1:0]         cnt       [LC3B_NUM_REGS];
  logic [LC3B_NUM_REGS-1:0] inc_vec;
  logic [LC3B_NUM_REGS-1:0] dec_vec;
  logic [LC3B_NUM_REGS-1:0] underflow;
  logic                     haz_a;
  logic                     haz_b;
  logic                     fire;

  // Register array write port; R0 is an ordinary register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LC3B_NUM_REGS; i++) begin
        regs[i] <= {WIDTH{1'b0}};
      end
    end else if (wb_ld) begin
      regs[wb_dest] <= wb_data;
    end else begin
      regs[wb_dest] <= regs[wb_dest];
    end
  end

  // Read ports with zero-cycle write-first bypass from the writeback bus.
  always_comb begin
    if (wb_ld && (wb_dest == src_a)) begin
      reada = wb_data;
    end else begin
      reada = regs[src_a];
    end
    if (wb_ld && (wb_dest == src_b)) begin
      readb = wb_data;
    end else begin
      readb = regs[src_b];
    end
  end

  // Source hazards; a lone outstanding write landing now is covered by the bypass.
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    if (issue_use_a && (cnt[src_a] != CNT_ZERO)) begin
      if (wb_ld && (wb_dest == src_a) && (cnt[src_a] == CNT_ONE)) begin
        haz_a = 1'b0;
      end else begin
        haz_a = 1'b1;
      end
    end else begin
      haz_a = 1'b0;
    end
    if (issue_use_b && (cnt[src_b] != CNT_ZERO)) begin
      if (wb_ld && (wb_dest == src_b) && (cnt[src_b] == CNT_ONE)) begin
        haz_b = 1'b0;
      end else begin
        haz_b = 1'b1;
      end
    end else begin
      haz_b = 1'b0;
    end
  end

  // Stall depends only on current inputs and registered counts, so fire is loop-free.
  always_comb begin
    if (issue_valid) begin
      stall = haz_a || haz_b || (issue_ld && (cnt[issue_dest] == CNT_MAX));
    end else begin
      stall = 1'b0;
    end
    fire = issue_valid && !stall;
  end

  // Per-register increment/decrement strobes.
  always_comb begin
    if (fire && issue_ld) begin
      inc_vec = reg_onehot(issue_dest);
    end else begin
      inc_vec = {LC3B_NUM_REGS{1'b0}};
    end
    if (wb_ld) begin
      dec_vec = reg_onehot(wb_dest);
    end else begin
      dec_vec = {LC3B_NUM_REGS{1'b0}};
    end
  end

  for (genvar g = 0; g < LC3B_NUM_REGS; g++) begin : g_cnt
    lc3b_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (inc_vec[g]),
      .dec      (dec_vec[g]),
      .cnt      (cnt[g]),
      .nonzero  (busy[g]),
      .underflow(underflow[g])
    );
  end

  // Sticky scoreboard error; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_err <= 1'b0;
    end else if (|underflow) begin
      sb_err <= 1'b1;
    end else begin
      sb_err <= sb_err;
    end
  end

endmodule

// File: tb/tb_lc3b_regfile_sb.sv
// Self-checking bench for lc3b_regfile_sb: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_lc3b_regfile_sb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  src_a, src_b, wb_dest, issue_dest;
  logic [15:0] reada, readb, wb_data;
  logic        wb_ld, issue_valid, issue_use_a, issue_use_b, issue_ld;
  logic        stall, sb_err;
  logic [7:0]  busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int          mcnt [8];
  logic [15:0] mreg [8];
  bit          merr;

  lc3b_regfile_sb dut (
    .clk(clk), .reset_n(reset_n),
    .src_a(src_a), .src_b(src_b), .reada(reada), .readb(readb),
    .wb_ld(wb_ld), .wb_dest(wb_dest), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_use_a(issue_use_a), .issue_use_b(issue_use_b),
    .issue_ld(issue_ld), .issue_dest(issue_dest),
    .stall(stall), .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mcnt[i] = 0;
      mreg[i] = 16'h0000;
    end
    merr = 1'b0;
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] s);
    if (wb_ld && wb_dest == s) return wb_data;
    return mreg[s];
  endfunction

  function automatic bit exp_stall();
    bit ha, hb, full;
    ha   = issue_use_a && mcnt[src_a] > 0 && !(wb_ld && wb_dest == src_a && mcnt[src_a] == 1);
    hb   = issue_use_b && mcnt[src_b] > 0 && !(wb_ld && wb_dest == src_b && mcnt[src_b] == 1);
    full = issue_ld && mcnt[issue_dest] == 3;
    return issue_valid && (ha || hb || full);
  endfunction

  function automatic logic [7:0] exp_busy();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  function automatic void model_update(input bit st);
    bit fire;
    int n;
    fire = issue_valid && !st;
    for (int r = 0; r < 8; r++) begin
      n = mcnt[r];
      if (fire && issue_ld && issue_dest == r) n = n + 1;
      if (wb_ld && wb_dest == r) n = n - 1;
      if (n < 0) begin
        n = 0;
        merr = 1'b1;
      end
      mcnt[r] = n;
    end
    if (wb_ld) mreg[wb_dest] = wb_data;
  endfunction

  // Compare all outputs against the model, away from the clock edge.
  task automatic settle_check();
    #1;
    check("reada",  32'(reada),  32'(exp_read(src_a)));
    check("readb",  32'(readb),  32'(exp_read(src_b)));
    check("stall",  32'(stall),  32'(exp_stall()));
    check("busy",   32'(busy),   32'(exp_busy()));
    check("sb_err", 32'(sb_err), 32'(merr));
  endtask

  task automatic tick();
    bit st;
    st = exp_stall();
    @(posedge clk);
    if (reset_n) model_update(st);
    @(negedge clk);
  endtask

  task automatic idle();
    src_a = 3'd0; src_b = 3'd0; wb_ld = 1'b0; wb_dest = 3'd0; wb_data = 16'h0000;
    issue_valid = 1'b0; issue_use_a = 1'b0; issue_use_b = 1'b0;
    issue_ld = 1'b0; issue_dest = 3'd0;
  endtask

  task automatic issue(input logic [2:0] d);
    idle();
    issue_valid = 1'b1; issue_ld = 1'b1; issue_dest = d;
  endtask

  task automatic wb(input logic [2:0] d, input logic [15:0] v);
    wb_ld = 1'b1; wb_dest = d; wb_data = v;
  endtask

  // Asynchronous reset pulse starting mid-cycle; ends aligned to a negedge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    settle_check();
    check("rst_reada", 32'(reada), (wb_ld && wb_dest == src_a) ? 32'(wb_data) : 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_err",   32'(sb_err), 32'h0);
    @(posedge clk);
    settle_check();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    @(negedge clk);

    // Reset mid-cycle with a writeback on the bus to a non-selected register
    wb(3'd7, 16'hAAAA); src_a = 3'd1; src_b = 3'd2;
    do_reset();
    idle();
    settle_check();
    check("idle_reada", 32'(reada), 32'h0);
    check("idle_readb", 32'(readb), 32'h0);
    check("idle_stall", 32'(stall), 32'h0);
    tick();

    // Write with same-cycle bypass, then from the array
    idle(); wb(3'd3, 16'hBEEF); src_a = 3'd3;
    settle_check(); check("bypass_a", 32'(reada), 32'h0000BEEF);
    tick();
    idle(); src_a = 3'd3;
    settle_check(); check("array_a", 32'(reada), 32'h0000BEEF);
    tick();

    // RAW stall on R2 resolved by writeback bypass
    issue(3'd2); settle_check(); check("raw_fire", 32'(stall), 32'h0); tick();
    idle(); settle_check(); check("raw_busy", 32'(busy), 32'h04);
    issue_valid = 1'b1; issue_use_a = 1'b1; src_a = 3'd2;
    settle_check(); check("raw_stall", 32'(stall), 32'h1); tick();
    issue_valid = 1'b1; issue_use_a = 1'b1; src_a = 3'd2; wb(3'd2, 16'h1234);
    settle_check();
    check("raw_resolve", 32'(stall), 32'h0);
    check("raw_reada", 32'(reada), 32'h00001234);
    tick();
    idle(); settle_check(); check("raw_busy_clr", 32'(busy), 32'h00);

    // WAW saturation on R5
    for (int i = 0; i < 3; i++) begin
      issue(3'd5); settle_check(); tick();
    end
    issue(3'd5); settle_check(); check("sat_stall", 32'(stall), 32'h1); tick();
    issue(3'd5); wb(3'd5, 16'h0505); settle_check(); check("sat_wb_cycle", 32'(stall), 32'h1); tick();
    issue(3'd5); issue_use_a = 1'b1; src_a = 3'd5; wb(3'd5, 16'h0555);
    settle_check(); check("two_out_stall", 32'(stall), 32'h1); tick();
    issue(3'd5); settle_check(); check("unsat_fire", 32'(stall), 32'h0); tick();
    idle(); settle_check(); check("r5_busy", 32'(busy), 32'h20);
    wb(3'd5, 16'h5555); settle_check(); tick();
    idle(); wb(3'd5, 16'h5A5A); settle_check(); tick();
    idle(); settle_check(); check("r5_drained", 32'(busy), 32'h00); tick();

    // Simultaneous inc/dec on R1
    issue(3'd1); settle_check(); tick();
    issue(3'd1); wb(3'd1, 16'h0101); settle_check(); tick();
    idle(); settle_check(); check("incdec_busy1", 32'(busy), 32'h02);
    wb(3'd1, 16'h1111); settle_check(); tick();

    // Underflow on R6: error is sticky, register still written
    idle(); wb(3'd6, 16'h6666); settle_check(); tick();
    idle(); src_a = 3'd6; settle_check();
    check("uf_err", 32'(sb_err), 32'h1);
    check("uf_busy", 32'(busy), 32'h00);
    check("uf_reg6", 32'(reada), 32'h00006666);
    for (int i = 0; i < 4; i++) tick();
    settle_check(); check("uf_sticky", 32'(sb_err), 32'h1);
    do_reset();
    idle(); settle_check(); check("uf_cleared", 32'(sb_err), 32'h0); tick();

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      src_a = 3'($urandom_range(0, 7));
      src_b = 3'($urandom_range(0, 7));
      issue_valid = 1'($urandom_range(0, 1));
      issue_use_a = 1'($urandom_range(0, 1));
      issue_use_b = 1'($urandom_range(0, 1));
      issue_ld    = ($urandom_range(0, 3) != 0);
      issue_dest  = 3'($urandom_range(0, 7));
      wb_ld       = 1'($urandom_range(0, 1));
      wb_data     = 16'($urandom);
      r = $urandom_range(0, 7);
      if ($urandom_range(0, 19) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (mcnt[(r + k) % 8] != 0) begin
            r = (r + k) % 8;
            break;
          end
        end
      end
      wb_dest = 3'(r);
      if (cyc % 600 == 599) begin
        do_reset();
      end else begin
        settle_check();
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
